// File: rtl/ambm_pkg.sv
// ambm_pkg: shared types, widths and arithmetic helpers for the approximate Booth multiplier
package ambm_pkg;

    localparam int OP_W       = 16;
    localparam int PROD_W     = 32;
    localparam int NUM_DIGITS = 9;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    function automatic booth_digit_t booth_encode(input logic [2:0] w);
        booth_digit_t d;
        d.neg = w[2];
        d.one = w[1] ^ w[0];
        d.two = (w[2] & ~w[1] & ~w[0]) | (~w[2] & w[1] & w[0]);
        return d;
    endfunction

    // 3:2 compressors consume operands in arrival order until two rows remain, then one carry-propagate add
    function automatic logic [PROD_W-1:0] csa_reduce(input logic [NUM_DIGITS:0][PROD_W-1:0] ops);
        logic [PROD_W-1:0] t [3*NUM_DIGITS-1];
        for (int i = 0; i <= NUM_DIGITS; i++) t[i] = ops[i];
        for (int k = 0; k < NUM_DIGITS - 1; k++) begin
            t[NUM_DIGITS+1+2*k] = t[3*k] ^ t[3*k+1] ^ t[3*k+2];
            t[NUM_DIGITS+2+2*k] = ((t[3*k] & t[3*k+1]) | (t[3*k] & t[3*k+2]) | (t[3*k+1] & t[3*k+2])) << 1;
        end
        return t[3*NUM_DIGITS-3] + t[3*NUM_DIGITS-2];
    endfunction

endpackage

// File: rtl/ambm_booth_pp.sv
// ambm_booth_pp: one radix-4 Booth digit selecting a shifted partial product of X
module ambm_booth_pp
    import ambm_pkg::*;
#(
    parameter int SHIFT = 0
) (
    input  logic [2:0]        window,
    input  logic [OP_W-1:0]   x,
    output logic [PROD_W-1:0] pp,
    output logic              neg
);

    booth_digit_t      d;
    logic [OP_W:0]     mag;
    logic [PROD_W-1:0] mag_ext;

    // Negative digits emit ~(|d|*X) shifted; the +1 at column SHIFT is supplied separately via neg
    always_comb begin
        d       = booth_encode(window);
        mag     = d.one ? {1'b0, x} : d.two ? {x, 1'b0} : '0;
        mag_ext = {{(PROD_W-OP_W-1){1'b0}}, mag};
        pp      = (d.neg ? ~mag_ext : mag_ext) << SHIFT;
        neg     = d.neg;
    end

endmodule

// File: rtl/ambm_multiplier.sv
// ambm_multiplier: 2-stage 16x16 unsigned radix-4 Booth multiplier dropping the lowest APPROX_DIGITS digits
module ambm_multiplier
    import ambm_pkg::*;
#(
    parameter int APPROX_DIGITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   multiplier,
    input  logic [OP_W-1:0]   multiplicand,
    output logic              out_valid,
    output logic [PROD_W-1:0] product
);

    logic [2*NUM_DIGITS:0]                 y_ext;
    logic [NUM_DIGITS-1:0][PROD_W-1:0]     pp_d, pp_q;
    logic [NUM_DIGITS-1:0]                 neg_d, neg_q;
    logic                                  valid_d, valid_q;
    logic                                  out_valid_d, out_valid_q;
    logic [PROD_W-1:0]                     product_d, product_q;
    logic [PROD_W-1:0]                     corr;
    logic [PROD_W-1:0]                     sum;

    assign y_ext = {{(2*NUM_DIGITS-OP_W){1'b0}}, multiplier, 1'b0};

    // Dropped digits see a zero window so they contribute neither a row nor a correction bit
    for (genvar j = 0; j < NUM_DIGITS; j++) begin : g_pp
        ambm_booth_pp #(.SHIFT(2*j)) u_pp (
            .window (j < APPROX_DIGITS ? 3'b000 : y_ext[2*j+2:2*j]),
            .x      (multiplicand),
            .pp     (pp_d[j]),
            .neg    (neg_d[j])
        );
    end

    // Gather negation corrections into one row, reduce all rows, and hold the product across bubbles
    always_comb begin
        corr = '0;
        for (int j = 0; j < NUM_DIGITS; j++) corr[2*j] = neg_q[j];
        sum         = csa_reduce({corr, pp_q});
        valid_d     = in_valid;
        out_valid_d = valid_q;
        product_d   = valid_q ? sum : product_q;
    end

    // Stage 1 holds the selected partial products, stage 2 the summed product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp_q        <= '0;
            neg_q       <= '0;
            valid_q     <= 1'b0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else begin
            pp_q        <= pp_d;
            neg_q       <= neg_d;
            valid_q     <= valid_d;
            out_valid_q <= out_valid_d;
            product_q   <= product_d;
        end
    end

    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_ambm_multiplier.sv
// tb_ambm_multiplier: four instances (A=0,1,2,8) on shared stimulus, checked by per-instance scoreboards
module tb_ambm_multiplier;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] e;
    } sb_t;

    typedef struct {
        int          inst;
        logic [15:0] y;
        logic [15:0] x;
        logic [31:0] e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] mplier = '0;
    logic [15:0] mcand = '0;
    logic        ov_w [4];
    logic [31:0] prod_w [4];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          log_en = 1'b0;
    vec_t        tv [12];

    always #5 clk = ~clk;

    function automatic int a_of(input int i);
        return i == 0 ? 0 : i == 1 ? 1 : i == 2 ? 2 : 8;
    endfunction

    // product = X*Y - X*sum_{j<a} d_j*4^j, mod 2^32
    function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y, input int a);
        logic [17:0] ye;
        longint      err;
        longint      r;
        int          d;
        ye  = {2'b00, y};
        err = 0;
        for (int j = 0; j < a; j++) begin
            d = (ye[2*j] ? 1 : 0) - (ye[2*j+1] ? 2 : 0);
            if (j > 0) d = d + (ye[2*j-1] ? 1 : 0);
            err = err + longint'(d) * (longint'(1) << (2*j));
        end
        r = longint'(x) * longint'(y) - longint'(x) * err;
        return r[31:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : gd
        localparam int A = a_of(g);
        sb_t        sb [$];
        logic [1:0] vp;

        ambm_multiplier #(.APPROX_DIGITS(A)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .in_valid     (in_valid),
            .multiplier   (mplier),
            .multiplicand (mcand),
            .out_valid    (ov_w[g]),
            .product      (prod_w[g])
        );

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                vp <= 2'b00;
                sb.delete();
            end else begin
                vp <= {vp[0], in_valid};
                if (in_valid) sb.push_back('{mcand, mplier, model(mcand, mplier, A)});
            end
        end

        always @(negedge clk) begin
            sb_t s;
            if (!rst) begin
                chk("valid_align", 32'(ov_w[g]), 32'(vp[1]));
                if (ov_w[g]) begin
                    if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
                    else begin
                        s = sb.pop_front();
                        chk("scoreboard", prod_w[g], s.e);
                        if (log_en && g == 1)
                            $display("seq A=%0d y=%0d x=%0d err=%0d", A, s.y, s.x,
                                     $signed(prod_w[g] - 32'(s.x) * 32'(s.y)));
                    end
                end
            end
        end
    end

    task automatic apply(input vec_t v);
        @(posedge clk); #1;
        in_valid = 1'b1; mplier = v.y; mcand = v.x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("tv_prod", prod_w[v.inst], v.e);
        chk("tv_valid", 32'(ov_w[v.inst]), 32'd1);
        @(posedge clk); #1;
        chk("tv_hold_prod", prod_w[v.inst], v.e);
        chk("tv_hold_valid", 32'(ov_w[v.inst]), 32'd0);
    endtask

    initial begin
        int r;
        tv[0]  = '{0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        tv[1]  = '{0, 16'h0000, 16'h1234, 32'd0};
        tv[2]  = '{0, 16'd62,   16'd65,   32'd4030};
        tv[3]  = '{1, 16'd4,    16'd3,    32'd12};
        tv[4]  = '{1, 16'd5,    16'd7,    32'd28};
        tv[5]  = '{1, 16'd62,   16'd65,   32'd4160};
        tv[6]  = '{1, 16'd1,    16'd9,    32'd0};
        tv[7]  = '{2, 16'hFFFF, 16'hFFFF, 32'hFFFF0000};
        tv[8]  = '{2, 16'd10,   16'd100,  32'd1600};
        tv[9]  = '{3, 16'h8000, 16'd3,    32'h00030000};
        tv[10] = '{3, 16'hFFFF, 16'hFFFF, 32'hFFFF0000};
        tv[11] = '{3, 16'h7FFF, 16'h1234, 32'd0};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_valid", 32'(ov_w[i]), 32'd0);
            chk("reset_prod", prod_w[i], 32'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 12; i++) apply(tv[i]);

        @(posedge clk); #1;
        in_valid = 1'b1; mplier = 16'h1234; mcand = 16'h0056;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_async_valid", 32'(ov_w[i]), 32'd0);
            chk("rst_async_prod", prod_w[i], 32'd0);
        end
        @(posedge clk);
        #5 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_lat1_valid", 32'(ov_w[0]), 32'd0);
        @(posedge clk); #1;
        chk("rst_lat2_valid", 32'(ov_w[0]), 32'd1);
        chk("rst_lat2_prod", prod_w[0], model(16'h0056, 16'h1234, 0));
        in_valid = 1'b0;
        repeat (3) @(posedge clk);

        log_en = 1'b1;
        for (int i = 0; i < 63; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; mplier = 16'(i); mcand = 16'(i + 3);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        log_en = 1'b0;

        for (int n = 0; n < 10000; n++) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(0, 7) != 0);
            r = $urandom_range(0, 9);
            mplier = r == 0 ? 16'hFFFF : r == 1 ? 16'h0000 : 16'($urandom);
            r = $urandom_range(0, 9);
            mcand = r == 0 ? 16'hFFFF : r == 1 ? 16'h0000 : 16'($urandom);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("sb_drain", 32'(gd[0].sb.size() + gd[1].sb.size() + gd[2].sb.size() + gd[3].sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
